// File: rtl/go_debouncer.sv
// Push-button conditioner: synchroniser plus a four-state stability filter.
// go_clean changes only after the synchronised input holds a new level long enough.
module go_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go_raw,
  output logic go_clean,
  output logic busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("go_debouncer: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
      $error("go_debouncer: STABLE_CYCLES must be >= 2");
    end
  endgenerate

  // Encoding puts go_clean in bit 1 and busy in bit 0, so outputs are flop bits.
  typedef enum logic [1:0] {
    LOW       = 2'b00,
    RISE_WAIT = 2'b01,
    HIGH      = 2'b10,
    FALL_WAIT = 2'b11
  } state_t;

  state_t                 state;
  state_t                 state_n;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   go_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], go_raw};
    end
  end

  assign go_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOW;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      LOW: begin
        if (go_s) begin
          state_n = RISE_WAIT;
          cnt_n   = CNT_ONE;
        end
      end
      RISE_WAIT: begin
        if (!go_s) begin
          state_n = LOW;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = HIGH;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!go_s) begin
          state_n = FALL_WAIT;
          cnt_n   = CNT_ONE;
        end
      end
      FALL_WAIT: begin
        if (go_s) begin
          state_n = HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = LOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = LOW;
        cnt_n   = '0;
      end
    endcase
  end

  assign go_clean = state[1];
  assign busy     = state[0];

endmodule

// File: tb/tb_go_debouncer.sv
// Directed bench for go_debouncer: per-clock vector table plus
// hand-written reset sequences.
module tb_go_debouncer;

  logic clk;
  logic rst_n;
  logic go_raw;
  logic go_clean;
  logic busy;

  int checks;
  int failures;
  int pulses;
  logic clean_q;

  typedef struct {
    logic go;
    logic clean;
    logic busy;
  } vec_t;

  vec_t tbl[$];

  go_debouncer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .go_raw   (go_raw),
    .go_clean (go_clean),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rising-edge detector standing in for the downstream consumer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_q <= 1'b0;
    end else begin
      clean_q <= go_clean;
      if (go_clean && !clean_q) pulses <= pulses + 1;
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_seg(input string g, input string c, input string b);
    vec_t v;
    for (int i = 0; i < g.len(); i++) begin
      v.go    = (g[i] == "1");
      v.clean = (c[i] == "1");
      v.busy  = (b[i] == "1");
      tbl.push_back(v);
    end
  endtask

  task automatic step(input logic g);
    @(negedge clk);
    go_raw = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic g, input int n);
    @(negedge clk);
    rst_n  = 1'b0;
    go_raw = g;
    #1;
    chk("reset_clean_imm", go_clean, 1'b0);
    chk("reset_busy_imm", busy, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("reset_clean", go_clean, 1'b0);
      chk("reset_busy", busy, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    pulses   = 0;
    rst_n    = 1'b0;
    go_raw   = 1'b1;

    // Reset held with the button pressed, then qualified high after release.
    do_reset(1'b1, 3);
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      chk("post_reset_rise", go_clean, (e == 6));
    end

    do_reset(1'b0, 2);
    pulses = 0;

    add_seg("001111111111", "000000011111", "000011100000");
    add_seg("0001111",      "1111111",      "0011100");
    add_seg("0000000",      "1111100",      "0011100");
    add_seg("10000",        "00000",        "00100");
    add_seg("1011111111",   "0000000111",   "0010111000");

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].go);
      chk($sformatf("tbl%0d_clean", i), go_clean, tbl[i].clean);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
    end
    chk_int("tbl_pulses", pulses, 2);

    // Reset while qualifying a rise with cnt at 2.
    do_reset(1'b0, 2);
    for (int i = 0; i < 4; i++) step(1'b1);
    chk("mid_wait_busy", busy, 1'b1);
    chk("mid_wait_clean", go_clean, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_clean", go_clean, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      chk("restart_rise", go_clean, (e >= 6));
      chk("restart_busy", busy, (e >= 3 && e <= 5));
    end
    chk_int("one_press_one_pulse", pulses, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
